// File: rtl/nios_system_pio_ack_gen.sv
// Avalon-MM PIO with edge capture, level irq and self-timed output strobes.
// Zero-wait-state reads; writes land on the next clk edge; no backpressure.
module nios_system_pio_ack_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int EDGE_TYPE    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    typedef logic [DATA_WIDTH-1:0] dat_t;
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES);

    dat_t       data_out_q, data_out_d;
    dat_t       irq_mask_q, irq_mask_d;
    dat_t       edge_cap_q, edge_cap_d;
    dat_t       pulse_bits_q, pulse_bits_d;
    logic [7:0] pulse_cnt_q, pulse_cnt_d;
    dat_t       in_meta_q, in_meta_d;
    dat_t       in_sync_q, in_sync_d;
    dat_t       in_prev_q, in_prev_d;
    logic [1:0] settle_q, settle_d;
    logic       irq_q, irq_d;

    logic       wr_en;
    logic       pulse_wr;
    dat_t       wdat;
    dat_t       w1c;
    dat_t       rise;
    dat_t       fall;
    dat_t       edges;
    logic       unused_wdat;

    assign wr_en       = chipselect & ~write_n;
    assign pulse_wr    = wr_en && (address == 3'd6);
    assign wdat        = writedata[DATA_WIDTH-1:0];
    assign unused_wdat = ^writedata;

    always_comb begin
        rise = in_sync_q & ~in_prev_q;
        fall = ~in_sync_q & in_prev_q;
        if (EDGE_TYPE == 0) begin
            edges = rise;
        end else if (EDGE_TYPE == 1) begin
            edges = fall;
        end else begin
            edges = rise | fall;
        end
    end

    always_comb begin
        data_out_d   = data_out_q;
        irq_mask_d   = irq_mask_q;
        pulse_bits_d = pulse_bits_q;
        pulse_cnt_d  = pulse_cnt_q;
        w1c          = '0;

        if (wr_en) begin
            case (address)
                3'd0:    data_out_d = wdat;
                3'd2:    irq_mask_d = wdat;
                3'd3:    w1c = wdat;
                3'd4:    data_out_d = data_out_q | wdat;
                3'd5:    data_out_d = data_out_q & ~wdat;
                3'd6: begin
                    pulse_bits_d = pulse_bits_q | wdat;
                    pulse_cnt_d  = PULSE_LOAD;
                end
                default: ;
            endcase
        end

        // A retrigger write reloads the counter instead of letting it expire.
        if (!pulse_wr && pulse_cnt_q != 8'd0) begin
            pulse_cnt_d = pulse_cnt_q - 8'd1;
            if (pulse_cnt_q == 8'd1) begin
                pulse_bits_d = '0;
            end
        end

        edge_cap_d = (edge_cap_q & ~w1c) | edges;

        // For two cycles after reset in_prev tracks in_sync so that the
        // synchroniser filling up from zero never looks like an edge.
        in_meta_d = in_port;
        in_sync_d = in_meta_q;
        in_prev_d = (settle_q != 2'd0) ? in_meta_q : in_sync_q;
        settle_d  = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;

        irq_d = |(edge_cap_q & irq_mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q   <= '0;
            irq_mask_q   <= '0;
            edge_cap_q   <= '0;
            pulse_bits_q <= '0;
            pulse_cnt_q  <= '0;
            in_meta_q    <= '0;
            in_sync_q    <= '0;
            in_prev_q    <= '0;
            settle_q     <= 2'd2;
            irq_q        <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            irq_mask_q   <= irq_mask_d;
            edge_cap_q   <= edge_cap_d;
            pulse_bits_q <= pulse_bits_d;
            pulse_cnt_q  <= pulse_cnt_d;
            in_meta_q    <= in_meta_d;
            in_sync_q    <= in_sync_d;
            in_prev_q    <= in_prev_d;
            settle_q     <= settle_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = 32'(in_sync_q);
            3'd1: readdata = 32'(data_out_q);
            3'd2: readdata = 32'(irq_mask_q);
            3'd3: readdata = 32'(edge_cap_q);
            3'd6: begin
                readdata     = 32'(pulse_bits_q);
                readdata[31] = readdata[31] | (pulse_cnt_q != 8'd0);
            end
            default: readdata = '0;
        endcase
    end

    assign out_port = data_out_q | pulse_bits_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_pio_ack_gen.sv
// Bench for nios_system_pio_ack_gen: directed scenarios plus randomized traffic
// compared against a timestamp/history based reference model.
module tb_nios_system_pio_ack_gen;

    localparam int DW = 8;
    localparam int P  = 4;
    localparam int HM = 8191;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [2:0]    address    = 3'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port    = '0;
    logic [DW-1:0] out_port;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    nios_system_pio_ack_gen #(
        .DATA_WIDTH  (DW),
        .PULSE_CYCLES(P),
        .EDGE_TYPE   (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: edge index n, sample history s[], last reset edge r,
    // and the edge index at which the current strobe expires.
    int            n    = 0;
    int            r    = -100;
    int            pend = 0;
    logic [DW-1:0] s [0:HM];
    logic [DW-1:0] m_dout  = '0;
    logic [DW-1:0] m_mask  = '0;
    logic [DW-1:0] m_cap   = '0;
    logic [DW-1:0] m_pbits = '0;
    logic          m_irq   = 1'b0;

    function automatic logic [DW-1:0] m_sync();
        if (n >= r + 2) return s[(n - 1) & HM];
        return '0;
    endfunction

    function automatic logic [DW-1:0] m_prev();
        if (n >= r + 3) return s[(n - 2) & HM];
        if (n == r + 2) return s[(n - 1) & HM];
        return '0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_sync());
            3'd1:    return 32'(m_dout);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_cap);
            3'd6:    return {(n < pend), 23'd0, m_pbits};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [DW-1:0] edg;
        logic [DW-1:0] w1c;
        logic          irq_nx;
        edg    = m_sync() & ~m_prev();
        irq_nx = |(m_cap & m_mask);
        n      = n + 1;
        s[n & HM] = in_port;
        w1c    = '0;
        if (reset) begin
            m_dout  = '0;
            m_mask  = '0;
            m_cap   = '0;
            m_pbits = '0;
            m_irq   = 1'b0;
            r       = n;
            pend    = 0;
        end else begin
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_dout = writedata[DW-1:0];
                    3'd2: m_mask = writedata[DW-1:0];
                    3'd3: w1c = writedata[DW-1:0];
                    3'd4: m_dout = m_dout | writedata[DW-1:0];
                    3'd5: m_dout = m_dout & ~writedata[DW-1:0];
                    3'd6: begin
                        m_pbits = m_pbits | writedata[DW-1:0];
                        pend    = n + P;
                    end
                    default: ;
                endcase
            end
            m_cap = (m_cap & ~w1c) | edg;
            m_irq = irq_nx;
            if (n >= pend) m_pbits = '0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Called at a negedge; the write lands on the following posedge and the
    // task returns at the negedge after it.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_port !== '0) begin
            failures++;
            $display("FAIL reset_out_port got=%h exp=00", out_port);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            checks++;
            if (readdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got=%h exp=00000000", a, readdata);
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_data_out();
        bus_write(3'd0, 32'hA5);
        checks++;
        if (out_port !== 8'hA5) begin
            failures++;
            $display("FAIL wr0_out_port got=%h exp=a5", out_port);
        end
        address = 3'd1;
        #1;
        checks++;
        if (readdata !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL rd1_data_out got=%h exp=000000a5", readdata);
        end
        bus_write(3'd4, 32'h0F);
        checks++;
        if (out_port !== 8'hAF) begin
            failures++;
            $display("FAIL set4_out_port got=%h exp=af", out_port);
        end
        bus_write(3'd5, 32'h81);
        checks++;
        if (out_port !== 8'h2E) begin
            failures++;
            $display("FAIL clr5_out_port got=%h exp=2e", out_port);
        end
        for (int a = 4; a < 8; a++) begin
            if (a == 6) continue;
            address = 3'(a);
            #1;
            checks++;
            if (readdata !== 32'd0) begin
                failures++;
                $display("FAIL rd_zero addr=%0d got=%h exp=00000000", a, readdata);
            end
        end
    endtask

    task automatic test_edge_irq();
        bus_write(3'd2, 32'h01);
        address = 3'd2;
        #1;
        checks++;
        if (readdata !== 32'h1) begin
            failures++;
            $display("FAIL rd2_mask got=%h exp=00000001", readdata);
        end
        bus_write(3'd3, 32'hFF);
        in_port = 8'h01;
        @(negedge clk);
        @(negedge clk);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL edge_after2 got=%h exp=00000000", readdata);
        end
        @(negedge clk);
        checks++;
        if (readdata !== 32'h1) begin
            failures++;
            $display("FAIL edge_after3 got=%h exp=00000001", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_after3 got=%b exp=0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_after4 got=%b exp=1", irq);
        end
        bus_write(3'd3, 32'h01);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL w1c_cap got=%h exp=00000000", readdata);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_w1c_hold got=%b exp=1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_w1c_drop got=%b exp=0", irq);
        end
    endtask

    task automatic test_edge_w1c_collision();
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'hFF);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL falling_ignored got=%h exp=00000000", readdata);
        end
        in_port = 8'h01;
        @(negedge clk);
        @(negedge clk);
        bus_write(3'd3, 32'h01);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h1) begin
            failures++;
            $display("FAIL collision_set_wins got=%h exp=00000001", readdata);
        end
        bus_write(3'd3, 32'h01);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL w1c_after_collision got=%h exp=00000000", readdata);
        end
    endtask

    task automatic test_pulse();
        bus_write(3'd0, 32'h00);
        bus_write(3'd6, 32'h02);
        address = 3'd6;
        for (int i = 0; i < P; i++) begin
            #1;
            checks++;
            if (out_port !== 8'h02 || readdata !== 32'h8000_0002) begin
                failures++;
                $display("FAIL pulse_active cyc=%0d out=%h rd=%h exp out=02 rd=80000002",
                         i, out_port, readdata);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (out_port !== 8'h00 || readdata !== 32'h0) begin
            failures++;
            $display("FAIL pulse_end out=%h rd=%h exp out=00 rd=00000000", out_port, readdata);
        end
        bus_write(3'd6, 32'h02);
        checks++;
        if (out_port !== 8'h02) begin
            failures++;
            $display("FAIL retrig_first got=%h exp=02", out_port);
        end
        @(negedge clk);
        bus_write(3'd6, 32'h04);
        address = 3'd6;
        for (int i = 0; i < P; i++) begin
            #1;
            checks++;
            if (out_port !== 8'h06 || readdata !== 32'h8000_0006) begin
                failures++;
                $display("FAIL retrig_active cyc=%0d out=%h rd=%h exp out=06 rd=80000006",
                         i, out_port, readdata);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (out_port !== 8'h00 || readdata !== 32'h0) begin
            failures++;
            $display("FAIL retrig_end out=%h rd=%h exp out=00 rd=00000000", out_port, readdata);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bus_write(3'd2, 32'hFF);
        in_port = 8'h03;
        repeat (4) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq got=%b exp=1", irq);
        end
        bus_write(3'd0, 32'h10);
        bus_write(3'd6, 32'h08);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        address = 3'd6;
        #1;
        checks++;
        if (out_port !== 8'h00 || readdata !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL mid_pulse_reset out=%h rd6=%h irq=%b exp 00/00000000/0",
                     out_port, readdata, irq);
        end
        address = 3'd2;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mask got=%h exp=00000000", readdata);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL no_edge_after_reset got=%h exp=00000000", readdata);
        end
        address = 3'd0;
        #1;
        checks++;
        if (readdata !== 32'h3) begin
            failures++;
            $display("FAIL rd0_in_sync got=%h exp=00000003", readdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            chipselect = ($urandom_range(0, 9) < 6);
            write_n    = ($urandom_range(0, 9) < 4);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ DW'($urandom);
            #1;
            exp_rd = m_rd(address);
            checks++;
            if (readdata !== exp_rd) begin
                failures++;
                $display("FAIL rand_read i=%0d addr=%0d got=%h exp=%h", i, address, readdata, exp_rd);
            end
            checks++;
            if (out_port !== (m_dout | m_pbits)) begin
                failures++;
                $display("FAIL rand_out_port i=%0d got=%h exp=%h", i, out_port, m_dout | m_pbits);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, m_irq);
            end
            @(negedge clk);
        end
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_data_out();
        test_edge_irq();
        test_edge_w1c_collision();
        test_pulse();
        test_reset_mid_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
